// File: rtl/compound_rr_scheduler.sv
// Round-robin scheduler: several producers share one compound-message
// output channel ({x,y} with a notify/sync handshake). A grant captures the
// winner's message and acknowledges it with a one-cycle in_sync pulse. The
// message is held downstream until the consumer syncs, and then the priority
// pointer moves to the requester after the one just served.
module compound_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        in_notify,
  input  logic [NUM_REQ*DATA_W-1:0] in_x,
  input  logic [NUM_REQ*DATA_W-1:0] in_y,
  output logic [NUM_REQ-1:0]        in_sync,
  output logic [DATA_W-1:0]         out_x,
  output logic [DATA_W-1:0]         out_y,
  output logic                      out_notify,
  input  logic                      out_sync,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_idx,
  output logic [31:0]               xfer_count
);

  // Section FSM encoding
  localparam logic [0:0] SECTION_IDLE = 1'b0;
  localparam logic [0:0] SECTION_SEND = 1'b1;

  // Registered state
  logic [0:0]         state_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   grant_idx_r;
  logic [DATA_W-1:0]  out_x_r;
  logic [DATA_W-1:0]  out_y_r;
  logic               out_notify_r;
  logic               busy_r;
  logic [NUM_REQ-1:0] in_sync_r;
  logic [31:0]        xfer_count_r;

  // Next-state values
  logic [0:0]         state_s;
  logic [IDX_W-1:0]   rr_ptr_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic [DATA_W-1:0]  out_x_s;
  logic [DATA_W-1:0]  out_y_s;
  logic               out_notify_s;
  logic               busy_s;
  logic [NUM_REQ-1:0] in_sync_s;
  logic [31:0]        xfer_count_s;

  // Arbitration results
  logic               found_s;
  logic [IDX_W-1:0]   pick_idx_s;
  int                 cand_s;
  logic [DATA_W-1:0]  pick_x_s;
  logic [DATA_W-1:0]  pick_y_s;
  logic [IDX_W-1:0]   rr_after_s;
  logic [NUM_REQ-1:0] pick_onehot_s;

  // Scan requesters starting at rr_ptr and wrapping; the first set notify wins
  always_comb begin
    found_s    = 1'b0;
    pick_idx_s = '0;
    cand_s     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = int'(rr_ptr_r) + k;
      if (cand_s >= NUM_REQ) begin
        cand_s = cand_s - NUM_REQ;
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && in_notify[cand_s]) begin
        found_s    = 1'b1;
        pick_idx_s = IDX_W'(cand_s);
      end else begin
        found_s    = found_s;
      end
    end
  end

  // Select the winner's payload, its acknowledge bit, and the pointer that follows the current grant
  always_comb begin
    pick_x_s      = in_x[int'(pick_idx_s)*DATA_W +: DATA_W];
    pick_y_s      = in_y[int'(pick_idx_s)*DATA_W +: DATA_W];
    pick_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
    if (grant_idx_r == IDX_W'(NUM_REQ-1)) begin
      rr_after_s = '0;
    end else begin
      rr_after_s = grant_idx_r + IDX_W'(1);
    end
  end

  // Section FSM next-state logic; in_sync defaults low so it can only pulse for one cycle
  always_comb begin
    state_s      = state_r;
    rr_ptr_s     = rr_ptr_r;
    grant_idx_s  = grant_idx_r;
    out_x_s      = out_x_r;
    out_y_s      = out_y_r;
    out_notify_s = out_notify_r;
    busy_s       = busy_r;
    in_sync_s    = '0;
    xfer_count_s = xfer_count_r;
    case (state_r)
      SECTION_IDLE: begin
        if (en && found_s) begin
          out_x_s      = pick_x_s;
          out_y_s      = pick_y_s;
          out_notify_s = 1'b1;
          grant_idx_s  = pick_idx_s;
          in_sync_s    = pick_onehot_s;
          busy_s       = 1'b1;
          state_s      = SECTION_SEND;
        end else begin
          state_s      = SECTION_IDLE;
        end
      end
      SECTION_SEND: begin
        // The captured message stays put and new notifies are ignored until the consumer syncs
        if (out_sync) begin
          out_notify_s = 1'b0;
          busy_s       = 1'b0;
          rr_ptr_s     = rr_after_s;
          xfer_count_s = xfer_count_r + 32'd1;
          state_s      = SECTION_IDLE;
        end else begin
          state_s      = SECTION_SEND;
        end
      end
      default: begin
        out_notify_s = 1'b0;
        busy_s       = 1'b0;
        state_s      = SECTION_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight message without acknowledging it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= SECTION_IDLE;
      rr_ptr_r     <= '0;
      grant_idx_r  <= '0;
      out_x_r      <= '0;
      out_y_r      <= '0;
      out_notify_r <= 1'b0;
      busy_r       <= 1'b0;
      in_sync_r    <= '0;
      xfer_count_r <= 32'd0;
    end else begin
      state_r      <= state_s;
      rr_ptr_r     <= rr_ptr_s;
      grant_idx_r  <= grant_idx_s;
      out_x_r      <= out_x_s;
      out_y_r      <= out_y_s;
      out_notify_r <= out_notify_s;
      busy_r       <= busy_s;
      in_sync_r    <= in_sync_s;
      xfer_count_r <= xfer_count_s;
    end
  end

  assign in_sync    = in_sync_r;
  assign out_x      = out_x_r;
  assign out_y      = out_y_r;
  assign out_notify = out_notify_r;
  assign busy       = busy_r;
  assign grant_idx  = grant_idx_r;
  assign xfer_count = xfer_count_r;

endmodule

// File: tb/tb_compound_rr_scheduler.sv
// Self-checking bench for compound_rr_scheduler (NUM_REQ=4, DATA_W=32).
// Expected grants go into a scoreboard queue as stimulus is driven; a
// negedge monitor pops and compares them whenever out_notify rises.
module tb_compound_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] x;
    logic [31:0] y;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         out_sync = 1'b0;
  logic [3:0]   in_notify = 4'b0000;
  logic [31:0]  tx [4];
  logic [31:0]  ty [4];
  logic [127:0] in_x;
  logic [127:0] in_y;
  logic [3:0]   in_sync;
  logic [31:0]  out_x;
  logic [31:0]  out_y;
  logic         out_notify;
  logic         busy;
  logic [1:0]   grant_idx;
  logic [31:0]  xfer_count;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_notify = 1'b0;
  logic [3:0] mon_onehot;
  logic [31:0] exp_xfer = 32'd0;

  compound_rr_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in_notify(in_notify), .in_x(in_x), .in_y(in_y), .in_sync(in_sync),
    .out_x(out_x), .out_y(out_y), .out_notify(out_notify), .out_sync(out_sync),
    .busy(busy), .grant_idx(grant_idx), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      in_x[i*32 +: 32] = tx[i];
      in_y[i*32 +: 32] = ty[i];
    end
  end

  // Scoreboard monitor: every rising out_notify must match the next expected grant
  always @(negedge clk) begin
    if (out_notify && !prev_notify) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_grant: got grant idx %0d, expected no grant", grant_idx);
      end else begin
        mon_e = exp_q.pop_front();
        mon_onehot = 4'b0001 << mon_e.idx;
        checks++;
        if (grant_idx !== mon_e.idx) begin errors++; $display("FAIL sb_grant_idx: got %0d expected %0d", grant_idx, mon_e.idx); end
        checks++;
        if (out_x !== mon_e.x) begin errors++; $display("FAIL sb_out_x: got %h expected %h", out_x, mon_e.x); end
        checks++;
        if (out_y !== mon_e.y) begin errors++; $display("FAIL sb_out_y: got %h expected %h", out_y, mon_e.y); end
        checks++;
        if (in_sync !== mon_onehot) begin errors++; $display("FAIL sb_in_sync: got %b expected %b", in_sync, mon_onehot); end
      end
    end else begin
      checks++;
      if (in_sync !== 4'b0000) begin errors++; $display("FAIL in_sync_pulse: got %b expected 0000", in_sync); end
    end
    prev_notify = out_notify;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; out_sync = 1'b1; in_notify = 4'b1111;
    for (int i = 0; i < 4; i++) begin tx[i] = 32'h1000 + i; ty[i] = 32'h2000 + i; end
    repeat (3) step();
    checks++; if (out_notify !== 1'b0) begin errors++; $display("FAIL rst_out_notify: got %b expected 0", out_notify); end
    checks++; if (out_x !== 32'd0) begin errors++; $display("FAIL rst_out_x: got %h expected 0", out_x); end
    checks++; if (out_y !== 32'd0) begin errors++; $display("FAIL rst_out_y: got %h expected 0", out_y); end
    checks++; if (in_sync !== 4'b0000) begin errors++; $display("FAIL rst_in_sync: got %b expected 0000", in_sync); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL rst_grant_idx: got %0d expected 0", grant_idx); end
    checks++; if (xfer_count !== 32'd0) begin errors++; $display("FAIL rst_xfer_count: got %0d expected 0", xfer_count); end
    en = 1'b0; rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if (in_sync !== 4'b0000) begin errors++; $display("FAIL en_low_in_sync: got %b expected 0000", in_sync); end
      checks++; if (out_notify !== 1'b0) begin errors++; $display("FAIL en_low_out_notify: got %b expected 0", out_notify); end
    end
    in_notify = 4'b0000;
    step();
  endtask

  task automatic test_single();
    tx[2] = 32'd5; ty[2] = 32'd7; en = 1'b1; out_sync = 1'b1;
    exp_q.push_back({2'd2, 32'd5, 32'd7});
    in_notify = 4'b0100;
    step();
    checks++; if (out_notify !== 1'b1) begin errors++; $display("FAIL single_notify: got %b expected 1", out_notify); end
    checks++; if (out_x !== 32'd5) begin errors++; $display("FAIL single_x: got %h expected 5", out_x); end
    checks++; if (out_y !== 32'd7) begin errors++; $display("FAIL single_y: got %h expected 7", out_y); end
    checks++; if (in_sync !== 4'b0100) begin errors++; $display("FAIL single_sync: got %b expected 0100", in_sync); end
    checks++; if (grant_idx !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d expected 2", grant_idx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    in_notify = 4'b0000;
    step();
    exp_xfer = 32'd1;
    checks++; if (out_notify !== 1'b0) begin errors++; $display("FAIL single_done_notify: got %b expected 0", out_notify); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_done_busy: got %b expected 0", busy); end
    checks++; if (xfer_count !== exp_xfer) begin errors++; $display("FAIL single_xfer: got %0d expected %0d", xfer_count, exp_xfer); end
    // rr_ptr must now be 3: with everyone requesting, requester 3 wins
    for (int i = 0; i < 4; i++) begin tx[i] = 32'h10 + i; ty[i] = 32'h20 + i; end
    exp_q.push_back({2'd3, 32'h13, 32'h23});
    in_notify = 4'b1111;
    step();
    checks++; if (grant_idx !== 2'd3) begin errors++; $display("FAIL rr_ptr_after_single: got %0d expected 3", grant_idx); end
    in_notify = 4'b0000;
    step();
    exp_xfer = 32'd2;
    checks++; if (xfer_count !== exp_xfer) begin errors++; $display("FAIL single_xfer2: got %0d expected %0d", xfer_count, exp_xfer); end
    step();
  endtask

  task automatic test_rotation();
    logic exp_n;
    for (int i = 0; i < 4; i++) begin tx[i] = i; ty[i] = 32'h100 + i; end
    exp_q.push_back({2'd0, 32'd0, 32'h100});
    exp_q.push_back({2'd1, 32'd1, 32'h101});
    exp_q.push_back({2'd2, 32'd2, 32'h102});
    exp_q.push_back({2'd3, 32'd3, 32'h103});
    exp_q.push_back({2'd0, 32'd0, 32'h100});
    out_sync = 1'b1; en = 1'b1; in_notify = 4'b1111;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_n = (k % 2 == 1) ? 1'b1 : 1'b0;
      checks++; if (out_notify !== exp_n) begin errors++; $display("FAIL rot_spacing_%0d: got %b expected %b", k, out_notify, exp_n); end
    end
    in_notify = 4'b0000;
    step();
    exp_xfer = exp_xfer + 32'd5;
    checks++; if (xfer_count !== exp_xfer) begin errors++; $display("FAIL rot_xfer: got %0d expected %0d", xfer_count, exp_xfer); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rot_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    tx[1] = 32'hDEAD; ty[1] = 32'hBEEF; out_sync = 1'b0;
    exp_q.push_back({2'd1, 32'hDEAD, 32'hBEEF});
    in_notify = 4'b0010;
    step();
    checks++; if (grant_idx !== 2'd1) begin errors++; $display("FAIL stall_grant: got %0d expected 1", grant_idx); end
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) begin tx[i] = $urandom; ty[i] = $urandom; end
      in_notify = 4'($urandom_range(0, 15));
      step();
      checks++; if (out_x !== 32'hDEAD) begin errors++; $display("FAIL stall_x: got %h expected dead", out_x); end
      checks++; if (out_y !== 32'hBEEF) begin errors++; $display("FAIL stall_y: got %h expected beef", out_y); end
      checks++; if (out_notify !== 1'b1) begin errors++; $display("FAIL stall_notify: got %b expected 1", out_notify); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b expected 1", busy); end
      checks++; if (xfer_count !== exp_xfer) begin errors++; $display("FAIL stall_xfer: got %0d expected %0d", xfer_count, exp_xfer); end
    end
    in_notify = 4'b0000; out_sync = 1'b1;
    step();
    exp_xfer = exp_xfer + 32'd1;
    checks++; if (out_notify !== 1'b0) begin errors++; $display("FAIL stall_release_notify: got %b expected 0", out_notify); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_release_busy: got %b expected 0", busy); end
    checks++; if (xfer_count !== exp_xfer) begin errors++; $display("FAIL stall_release_xfer: got %0d expected %0d", xfer_count, exp_xfer); end
  endtask

  task automatic test_reset_mid();
    tx[3] = 32'hA5A5; ty[3] = 32'h5A5A; out_sync = 1'b0;
    exp_q.push_back({2'd3, 32'hA5A5, 32'h5A5A});
    in_notify = 4'b1000;
    step();
    checks++; if (out_notify !== 1'b1) begin errors++; $display("FAIL mid_grant_notify: got %b expected 1", out_notify); end
    in_notify = 4'b0000;
    step();
    #2;
    rst = 1'b0;
    #1;
    exp_xfer = 32'd0;
    checks++; if (out_notify !== 1'b0) begin errors++; $display("FAIL mid_rst_notify: got %b expected 0", out_notify); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    checks++; if (xfer_count !== exp_xfer) begin errors++; $display("FAIL mid_rst_xfer: got %0d expected 0", xfer_count); end
    checks++; if (out_x !== 32'd0) begin errors++; $display("FAIL mid_rst_x: got %h expected 0", out_x); end
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin tx[i] = 32'h30 + i; ty[i] = 32'h40 + i; end
    exp_q.push_back({2'd0, 32'h30, 32'h40});
    out_sync = 1'b1; in_notify = 4'b1111;
    step();
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL mid_after_rst_grant: got %0d expected 0", grant_idx); end
    in_notify = 4'b0000;
    step();
    exp_xfer = 32'd1;
    checks++; if (xfer_count !== exp_xfer) begin errors++; $display("FAIL mid_after_rst_xfer: got %0d expected 1", xfer_count); end
  endtask

  task automatic test_wrap_en();
    step();
    force dut.xfer_count_r = 32'hFFFF_FFFF;
    step();
    release dut.xfer_count_r;
    #1;
    checks++; if (xfer_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preset: got %h expected ffffffff", xfer_count); end
    tx[1] = 32'h77; ty[1] = 32'h88; tx[2] = 32'h99; ty[2] = 32'hAA;
    exp_q.push_back({2'd1, 32'h77, 32'h88});
    out_sync = 1'b0; en = 1'b1; in_notify = 4'b0010;
    step();
    checks++; if (out_notify !== 1'b1) begin errors++; $display("FAIL wrap_grant: got %b expected 1", out_notify); end
    en = 1'b0; in_notify = 4'b1111; out_sync = 1'b1;
    step();
    checks++; if (out_notify !== 1'b0) begin errors++; $display("FAIL en_drop_complete: got %b expected 0", out_notify); end
    checks++; if (xfer_count !== 32'd0) begin errors++; $display("FAIL wrap_xfer: got %h expected 0", xfer_count); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (out_notify !== 1'b0) begin errors++; $display("FAIL en_gate_notify: got %b expected 0", out_notify); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_gate_busy: got %b expected 0", busy); end
    end
    exp_q.push_back({2'd2, 32'h99, 32'hAA});
    en = 1'b1;
    step();
    checks++; if (grant_idx !== 2'd2) begin errors++; $display("FAIL en_resume_grant: got %0d expected 2", grant_idx); end
    checks++; if (out_notify !== 1'b1) begin errors++; $display("FAIL en_resume_notify: got %b expected 1", out_notify); end
    in_notify = 4'b0000;
    step();
    checks++; if (xfer_count !== 32'd1) begin errors++; $display("FAIL en_resume_xfer: got %0d expected 1", xfer_count); end
    step();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_stall();
    test_reset_mid();
    test_wrap_en();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
